// File: rtl/cla_seq_pkg.sv
// Shared types and constants for the sequential CLA adder.
// Holds the FSM state encoding and the nibble width.
package cla_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cla_nibble.sv
// Combinational 4-bit carry-lookahead adder slice.
// Generate/propagate form; carries are flat, not rippled.
module cla_nibble
  import cla_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  // Lookahead carries for every bit position
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    co   = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c;
  end

endmodule

// File: rtl/cla_seq_adder.sv
// Sequential adder: one shared CLA nibble, LSB nibble first.
// Macro CLA_SEQ_ADDER_OVF_EN adds the two's-complement ovf output.
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef CLA_SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  state_t state_q;
  state_t state_d;

  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                carry_q;
  logic                cout_q;
  logic [IW-1:0]       idx_q;
  logic [NIBBLE_W-1:0] na;
  logic [NIBBLE_W-1:0] nb;
  logic [NIBBLE_W-1:0] ns;
  logic                nco;
  logic                last;
  logic                accept;
  int                  base;

  assign base   = int'(idx_q) * NIBBLE_W;
  assign na     = a_q[base +: NIBBLE_W];
  assign nb     = b_q[base +: NIBBLE_W];
  assign last   = (idx_q == IW'(NIB - 1));
  assign accept = in_valid & in_ready;

  cla_nibble u_nib (
    .a  (na),
    .b  (nb),
    .ci (carry_q),
    .s  (ns),
    .co (nco)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      (state_q == IDLE): begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      (state_q == RUN): begin
        if (last) state_d = DONE;
      end
      (state_q == DONE): begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and one nibble per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else if (accept) begin
      a_q     <= op_a;
      b_q     <= op_b;
      carry_q <= c_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      sum_q[base +: NIBBLE_W] <= ns;
      carry_q <= nco;
      idx_q   <= idx_q + IW'(1);
      if (last) cout_q <= nco;
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;

`ifdef CLA_SEQ_ADDER_OVF_EN
  logic ovf_q;

  // Signed overflow: like-signed operands, differently signed result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= (na[3] == nb[3]) & (ns[3] != na[3]);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed bench for cla_seq_adder with a cycle-level
// reference model and literal per-vector expectations.
module tb_cla_seq_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
`ifdef CLA_SEQ_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  cla_seq_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
`ifdef CLA_SEQ_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: result is W/4 cycles after accept,
  // then held until consumed; operands ignored while busy.
  bit           m_idle;
  bit           m_valid;
  int           m_left;
  logic [W:0]   m_pend;
  bit           m_pov;
  logic [W-1:0] m_sum;
  bit           m_cout;
  bit           m_ovf;

  function automatic logic [W:0] ref_add(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci
  );
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  function automatic bit ref_ovf(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci
  );
    logic [W:0] r;
    r = ref_add(a, b, ci);
    return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle  <= 1'b1;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_pend  <= '0;
      m_pov   <= 1'b0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
      m_ovf   <= 1'b0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_idle <= 1'b0;
        m_left <= W / 4;
        m_pend <= ref_add(op_a, op_b, c_in);
        m_pov  <= ref_ovf(op_a, op_b, c_in);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_sum   <= m_pend[W-1:0];
        m_cout  <= m_pend[W];
        m_ovf   <= m_pov;
      end
    end else if (out_ready) begin
      m_valid <= 1'b0;
      m_idle  <= 1'b1;
    end
  end

  // Compare DUT against the model every cycle
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", {31'd0, in_ready},
          {31'd0, m_idle});
      chk("m_out_valid", {31'd0, out_valid},
          {31'd0, m_valid});
      if (m_idle || m_valid) begin
        chk("m_sum", {16'd0, sum}, {16'd0, m_sum});
        chk("m_c_out", {31'd0, c_out},
            {31'd0, m_cout});
      end
`ifdef CLA_SEQ_ADDER_OVF_EN
      if (m_valid)
        chk("m_ovf", {31'd0, ovf}, {31'd0, m_ovf});
`endif
    end
  end

  task automatic run(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ci,
    input int           hold,
    input logic [W-1:0] es,
    input logic         ec,
    input logic         eo
  );
    int lat;
    bit seen;
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ready_before", {31'd0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    op_a      = a;
    op_b      = b;
    c_in      = ci;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("ready_in_run", {31'd0, in_ready}, 32'd0);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      seen = out_valid;
    end
    chk("latency", lat, 32'd4);
    chk("sum", {16'd0, sum}, {16'd0, es});
    chk("c_out", {31'd0, c_out}, {31'd0, ec});
`ifdef CLA_SEQ_ADDER_OVF_EN
    chk("ovf", {31'd0, ovf}, {31'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      op_a     = 16'h1111;
      op_b     = 16'h2222;
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_sum", {16'd0, sum}, {16'd0, es});
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_after", {31'd0, in_ready}, 32'd1);
    chk("valid_after", {31'd0, out_valid}, 32'd0);
    chk("sum_held", {16'd0, sum}, {16'd0, es});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    c_in      = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_c_out", {31'd0, c_out}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run(16'h1234, 16'h4321, 1'b0, 0, 16'h5555, 1'b0, 1'b0);
    run(16'hFFFF, 16'h0001, 1'b0, 0, 16'h0000, 1'b1, 1'b0);
    run(16'h7FFF, 16'h0001, 1'b0, 0, 16'h8000, 1'b0, 1'b1);
    run(16'hFFFF, 16'hFFFF, 1'b1, 0, 16'hFFFF, 1'b1, 1'b0);
    run(16'h8000, 16'h8000, 1'b0, 0, 16'h0000, 1'b1, 1'b1);
    run(16'h0000, 16'h0000, 1'b1, 0, 16'h0001, 1'b0, 1'b0);
    run(16'hA5A5, 16'h5A5A, 1'b0, 5, 16'hFFFF, 1'b0, 1'b0);

    op_a     = 16'h9999;
    op_b     = 16'h9999;
    c_in     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_c_out", {31'd0, c_out}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);

    run(16'h0F0F, 16'h00F1, 1'b1, 0, 16'h1001, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cla_seq_adder.md
CLA_SEQ_ADDER -- requirements
Module: cla_seq_adder

Interface
REQ-001 The block SHALL have one clock and reset; reset is asynchronous and active-low.
REQ-002 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and >= 8.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port in_valid  input  1  operands presented.
REQ-006 Port in_ready  output  1  block can accept operands.
REQ-007 Port op_a  input  WIDTH  operand A.
REQ-008 Port op_b  input  WIDTH  operand B.
REQ-009 Port c_in  input  1  carry into nibble 0.
REQ-010 Port out_valid  output  1  result available.
REQ-011 Port out_ready  input  1  consumer accepts result.
REQ-012 Port sum  output  WIDTH  result.
REQ-013 Port c_out  output  1  carry out of the top nibble.

Function
REQ-014 The block SHALL sequence one shared 4-bit carry-lookahead nibble adder, one nibble per cycle, LSB nibble first, with the carry registered between cycles.
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, capture op_a, op_b and c_in, clear the nibble index, and go to RUN.
REQ-017 RUN: each cycle, add nibble[idx] of A and B with the carry register, write the result into sum[4*idx+3:4*idx], update the carry, and increment idx.
REQ-018 RUN SHALL exit to DONE after nibble WIDTH/4-1, so the result is ready WIDTH/4 cycles after the accept edge; with WIDTH=16, out_valid rises 4 cycles after acceptance.
REQ-019 DONE: out_valid=1, with sum and c_out stable; on out_valid&out_ready, go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid is ignored there (no queueing).
REQ-021 Carries SHALL ripple modulo 2^WIDTH; c_out is the carry out of the top nibble; all-ones + all-ones + c_in=1 yields sum=all-ones, c_out=1.
REQ-022 If out_ready is already 1 on DONE entry, the result is consumed in that cycle: DONE lasts 1 cycle and IDLE follows.
REQ-023 A new operand is accepted no earlier than the cycle after the return to IDLE; throughput is 1 result per WIDTH/4+2 cycles.
REQ-024 sum and c_out SHALL hold their last value in IDLE until the next RUN overwrites them.

Reset
REQ-025 Asserting rst_n low at any time, including mid-RUN, SHALL immediately force: state IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, carry register=0, idx=0.
REQ-026 A partial result SHALL never be presented after reset; operands captured before reset are discarded.

Configuration
REQ-027 Macro CLA_SEQ_ADDER_OVF_EN: when defined, the block SHALL add output port ovf (1 bit) = carry into the MSB XOR carry out of the MSB (two's-complement overflow), valid with out_valid and reset to 0.
REQ-028 Without CLA_SEQ_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-029 Package cla_seq_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the constant NIBBLE_W=4.
REQ-030 Sub-module cla_nibble SHALL be the purely combinational 4-bit generate/propagate adder: inputs a[3:0], b[3:0], ci; outputs s[3:0], co. It is instantiated exactly once.
REQ-031 The index counter width SHALL be $clog2(WIDTH/4), minimum 1.

Verification
REQ-032 WIDTH=16; A=0x1234, B=0x4321, c_in=0, out_ready=1 -> out_valid 4 cycles after accept; sum=0x5555, c_out=0.
REQ-033 A=0xFFFF, B=0x0001, c_in=0 -> sum=0x0000, c_out=1 (carry crosses all nibbles); with OVF_EN, ovf=0.
REQ-034 A=0x7FFF, B=0x0001, with OVF_EN -> sum=0x8000, c_out=0, ovf=1.
REQ-035 out_ready held 0 for 5 cycles after DONE -> out_valid and sum stay stable, in_ready=0, a concurrent in_valid is ignored; release -> IDLE next cycle.
REQ-036 rst_n pulsed low in the 2nd RUN cycle -> out_valid=0, sum=0 and in_ready=1 immediately; the next transaction (0x0F0F+0x00F1, c_in=1) gives sum=0x1001.
